// File: rtl/mil_sram_pkg.sv
// Shared types and default sizing for the SRAM controller.
package mil_sram_pkg;

  localparam int unsigned DefaultAddrW      = 16;
  localparam int unsigned DefaultDataW      = 16;
  localparam int unsigned DefaultWaitStates = 2;
  localparam int unsigned CntW              = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRecover
  } state_e;

endpackage

// File: rtl/mil_sram_controller_if.sv
// Memory-block side request/response bus of the SRAM controller.
interface mil_sram_controller_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_busy;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_busy, mem_ack, mem_rdata, mem_err
  );

  modport slave (
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_busy, mem_ack, mem_rdata, mem_err
  );

endinterface

// File: rtl/mil_sram_controller.sv
// Asynchronous SRAM controller: one access at a time with a programmable number of wait states.
// Every output is a flop so no mem_* input reaches the pins combinationally.
module mil_sram_controller
  import mil_sram_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefaultAddrW,
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned WAIT_STATES = DefaultWaitStates
) (
  input  logic              clk,
  input  logic              nRst,
  mil_sram_controller_if.slave mbus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_nCE,
  output logic              sram_nOE,
  output logic              sram_nWE
);

  if (WAIT_STATES > 15) begin : g_bad_wait
    $error("WAIT_STATES must be in 0..15");
  end

  localparam logic [CntW-1:0] WaitLoad = CntW'(WAIT_STATES);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              is_wr_q;
  logic              busy_q;
  logic              ack_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  assign mbus.mem_busy  = busy_q;
  assign mbus.mem_ack   = ack_q;
  assign mbus.mem_err   = err_q;
  assign mbus.mem_rdata = rdata_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_nCE   <= 1'b1;
      sram_nOE   <= 1'b1;
      sram_nWE   <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mbus.mem_rd || mbus.mem_wr) begin
            // A simultaneous rd+wr is resolved as a write and flagged.
            state_q    <= StAccess;
            cnt_q      <= WaitLoad;
            is_wr_q    <= mbus.mem_wr;
            err_q      <= mbus.mem_rd && mbus.mem_wr;
            busy_q     <= 1'b1;
            sram_addr  <= mbus.mem_addr;
            sram_dq_o  <= mbus.mem_wdata;
            sram_dq_oe <= mbus.mem_wr;
            sram_nCE   <= 1'b0;
            sram_nOE   <= mbus.mem_wr;
            sram_nWE   <= ~mbus.mem_wr;
          end
        end
        StAccess: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!is_wr_q) begin
              rdata_q <= sram_dq_i;
            end
            ack_q    <= 1'b1;
            state_q  <= StRecover;
            sram_nCE <= 1'b1;
            sram_nOE <= 1'b1;
            sram_nWE <= 1'b1;
          end
        end
        StRecover: begin
          // Write data stays driven through this cycle for SRAM hold time.
          state_q    <= StIdle;
          busy_q     <= 1'b0;
          sram_dq_oe <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mil_sram_controller.sv
// Directed bench: WAIT_STATES=2 controller on a small SRAM model, plus a WAIT_STATES=0 instance.
module tb_mil_sram_controller;

  logic clk;
  logic nRst;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: WAIT_STATES=2 with SRAM model ----------------
  mil_sram_controller_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
  logic [15:0] a_addr, a_dq_o, a_dq_i;
  logic        a_oe, a_nce, a_noe, a_nwe;
  logic [15:0] sram_mem [256];

  mil_sram_controller #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(2)) u_dut_a (
    .clk        (clk),
    .nRst       (nRst),
    .mbus       (bus_a.slave),
    .sram_addr  (a_addr),
    .sram_dq_o  (a_dq_o),
    .sram_dq_i  (a_dq_i),
    .sram_dq_oe (a_oe),
    .sram_nCE   (a_nce),
    .sram_nOE   (a_noe),
    .sram_nWE   (a_nwe)
  );

  assign a_dq_i = sram_mem[a_addr[7:0]];

  always @(posedge clk) begin
    if (!a_nce && !a_nwe) sram_mem[a_addr[7:0]] <= a_dq_o;
  end

  // ---------------- DUT B: WAIT_STATES=0, constant read data ----------------
  mil_sram_controller_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();
  logic [15:0] b_addr, b_dq_o, b_dq_i;
  logic        b_oe, b_nce, b_noe, b_nwe;

  mil_sram_controller #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0)) u_dut_b (
    .clk        (clk),
    .nRst       (nRst),
    .mbus       (bus_b.slave),
    .sram_addr  (b_addr),
    .sram_dq_o  (b_dq_o),
    .sram_dq_i  (b_dq_i),
    .sram_dq_oe (b_oe),
    .sram_nCE   (b_nce),
    .sram_nOE   (b_noe),
    .sram_nWE   (b_nwe)
  );

  // One request on DUT A, observed for ncyc cycles starting in the cycle after acceptance.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input int ncyc,
                           output int nwe_lo, output int noe_lo, output int oe_hi,
                           output int busy_hi, output int ack_cnt, output int ack_at,
                           output int err_cnt, output logic [15:0] rdata_ack,
                           output logic [15:0] addr0, output logic [15:0] dq0);
    nwe_lo = 0; noe_lo = 0; oe_hi = 0; busy_hi = 0;
    ack_cnt = 0; ack_at = -1; err_cnt = 0; rdata_ack = 'x; addr0 = 'x; dq0 = 'x;
    @(negedge clk);
    bus_a.mem_rd = rd; bus_a.mem_wr = wr; bus_a.mem_addr = addr; bus_a.mem_wdata = wdata;
    @(posedge clk);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus_a.mem_rd = 1'b0; bus_a.mem_wr = 1'b0;
        addr0 = a_addr; dq0 = a_dq_o;
      end
      if (!a_nwe) nwe_lo++;
      if (!a_noe) noe_lo++;
      if (a_oe) oe_hi++;
      if (bus_a.mem_busy) busy_hi++;
      if (bus_a.mem_err) err_cnt++;
      if (bus_a.mem_ack) begin
        ack_cnt++;
        ack_at = i;
        rdata_ack = bus_a.mem_rdata;
      end
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus_a.mem_busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %b, expected 0", bus_a.mem_busy); end
    n_checks++; if (bus_a.mem_ack !== 1'b0) begin n_fail++;
      $display("FAIL reset_ack: got %b, expected 0", bus_a.mem_ack); end
    n_checks++; if (bus_a.mem_err !== 1'b0) begin n_fail++;
      $display("FAIL reset_err: got %b, expected 0", bus_a.mem_err); end
    n_checks++; if (bus_a.mem_rdata !== 16'h0000) begin n_fail++;
      $display("FAIL reset_rdata: got %h, expected 0000", bus_a.mem_rdata); end
    n_checks++; if (a_addr !== 16'h0000) begin n_fail++;
      $display("FAIL reset_sram_addr: got %h, expected 0000", a_addr); end
    n_checks++; if (a_dq_o !== 16'h0000) begin n_fail++;
      $display("FAIL reset_dq_o: got %h, expected 0000", a_dq_o); end
    n_checks++; if ({a_nce, a_noe, a_nwe} !== 3'b111) begin n_fail++;
      $display("FAIL reset_strobes: got %b, expected 111", {a_nce, a_noe, a_nwe}); end
    n_checks++; if (a_oe !== 1'b0) begin n_fail++;
      $display("FAIL reset_dq_oe: got %b, expected 0", a_oe); end
    nRst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    int nwe, noe, oe, busy, ackc, acka, errc;
    logic [15:0] rd, ad0, dq0;
    do_access(1'b0, 1'b1, 16'h0010, 16'h1234, 6, nwe, noe, oe, busy, ackc, acka, errc, rd, ad0,
              dq0);
    n_checks++; if (nwe !== 3) begin n_fail++;
      $display("FAIL wr_nwe_cycles: got %0d, expected 3", nwe); end
    n_checks++; if (acka !== 3 || ackc !== 1) begin n_fail++;
      $display("FAIL wr_ack: got at %0d count %0d, expected at 3 count 1", acka, ackc); end
    n_checks++; if (oe !== 4) begin n_fail++;
      $display("FAIL wr_dq_oe_cycles: got %0d, expected 4", oe); end
    n_checks++; if (busy !== 4) begin n_fail++;
      $display("FAIL wr_busy_cycles: got %0d, expected 4", busy); end
    n_checks++; if (ad0 !== 16'h0010 || dq0 !== 16'h1234) begin n_fail++;
      $display("FAIL wr_pins: got %h/%h, expected 0010/1234", ad0, dq0); end
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 6, nwe, noe, oe, busy, ackc, acka, errc, rd, ad0,
              dq0);
    n_checks++; if (rd !== 16'h1234 || acka !== 3) begin n_fail++;
      $display("FAIL rd_data: got %h at %0d, expected 1234 at 3", rd, acka); end
    n_checks++; if (noe !== 3 || nwe !== 0 || oe !== 0) begin n_fail++;
      $display("FAIL rd_strobes: got noe %0d nwe %0d oe %0d, expected 3 0 0", noe, nwe, oe); end
    @(negedge clk);
    n_checks++; if (bus_a.mem_rdata !== 16'h1234) begin n_fail++;
      $display("FAIL rd_data_hold: got %h, expected 1234", bus_a.mem_rdata); end
  endtask

  task automatic test_rd_wr_both();
    int nwe, noe, oe, busy, ackc, acka, errc;
    logic [15:0] rd, ad0, dq0;
    do_access(1'b1, 1'b1, 16'h0020, 16'hA5A5, 6, nwe, noe, oe, busy, ackc, acka, errc, rd, ad0,
              dq0);
    n_checks++; if (errc !== 1) begin n_fail++;
      $display("FAIL both_err_pulses: got %0d, expected 1", errc); end
    n_checks++; if (noe !== 0 || nwe !== 3) begin n_fail++;
      $display("FAIL both_strobes: got noe %0d nwe %0d, expected 0 3", noe, nwe); end
    do_access(1'b1, 1'b0, 16'h0020, 16'h0000, 6, nwe, noe, oe, busy, ackc, acka, errc, rd, ad0,
              dq0);
    n_checks++; if (rd !== 16'hA5A5 || errc !== 0) begin n_fail++;
      $display("FAIL both_readback: got %h err %0d, expected a5a5 err 0", rd, errc); end
  endtask

  task automatic test_back_to_back();
    int starts[$];
    int busy, ackc;
    logic prev_nce;
    busy = 0; ackc = 0; prev_nce = 1'b1;
    @(negedge clk);
    bus_a.mem_rd = 1'b1; bus_a.mem_addr = 16'h0010;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!a_nce && prev_nce) starts.push_back(i);
      prev_nce = a_nce;
      if (bus_a.mem_busy) busy++;
      if (bus_a.mem_ack) ackc++;
      if (i == 5) bus_a.mem_rd = 1'b0;
    end
    n_checks++; if (starts.size() !== 2) begin n_fail++;
      $display("FAIL b2b_accepts: got %0d, expected 2", starts.size()); end
    else begin
      n_checks++; if (starts[1] - starts[0] !== 5) begin n_fail++;
        $display("FAIL b2b_spacing: got %0d, expected 5", starts[1] - starts[0]); end
    end
    n_checks++; if (busy !== 8) begin n_fail++;
      $display("FAIL b2b_busy_cycles: got %0d, expected 8", busy); end
    n_checks++; if (ackc !== 2) begin n_fail++;
      $display("FAIL b2b_acks: got %0d, expected 2", ackc); end
  endtask

  task automatic test_zero_wait();
    int noe, busy, acka, ackc;
    logic [15:0] rd;
    noe = 0; busy = 0; acka = -1; ackc = 0; rd = 'x;
    @(negedge clk);
    bus_b.mem_rd = 1'b1; bus_b.mem_addr = 16'h0003;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_b.mem_rd = 1'b0;
      if (!b_noe) noe++;
      if (bus_b.mem_busy) busy++;
      if (bus_b.mem_ack) begin ackc++; acka = i; rd = bus_b.mem_rdata; end
    end
    n_checks++; if (acka !== 1 || ackc !== 1) begin n_fail++;
      $display("FAIL ws0_ack: got at %0d count %0d, expected at 1 count 1", acka, ackc); end
    n_checks++; if (noe !== 1) begin n_fail++;
      $display("FAIL ws0_noe_cycles: got %0d, expected 1", noe); end
    n_checks++; if (rd !== 16'hBEEF) begin n_fail++;
      $display("FAIL ws0_rdata: got %h, expected beef", rd); end
    n_checks++; if (busy !== 2) begin n_fail++;
      $display("FAIL ws0_busy_cycles: got %0d, expected 2", busy); end
  endtask

  task automatic test_reset_abort();
    int ackc, nwe, noe, oe, busy, acka, errc;
    logic [15:0] rd, ad0, dq0;
    ackc = 0;
    @(negedge clk);
    bus_a.mem_wr = 1'b1; bus_a.mem_addr = 16'h0030; bus_a.mem_wdata = 16'h5555;
    @(posedge clk);
    #1 bus_a.mem_wr = 1'b0;
    @(posedge clk);
    #2 nRst = 1'b0;
    #1;
    n_checks++; if ({a_nce, a_noe, a_nwe} !== 3'b111) begin n_fail++;
      $display("FAIL abort_strobes: got %b, expected 111", {a_nce, a_noe, a_nwe}); end
    n_checks++; if (a_oe !== 1'b0 || bus_a.mem_busy !== 1'b0) begin n_fail++;
      $display("FAIL abort_oe_busy: got %b/%b, expected 0/0", a_oe, bus_a.mem_busy); end
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus_a.mem_ack) ackc++;
    end
    n_checks++; if (ackc !== 0) begin n_fail++;
      $display("FAIL abort_no_ack: got %0d acks, expected 0", ackc); end
    n_checks++; if (bus_a.mem_rdata !== 16'h0000) begin n_fail++;
      $display("FAIL abort_rdata_cleared: got %h, expected 0000", bus_a.mem_rdata); end
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 6, nwe, noe, oe, busy, ackc, acka, errc, rd, ad0,
              dq0);
    n_checks++; if (rd !== 16'h1234 || acka !== 3) begin n_fail++;
      $display("FAIL abort_fresh_read: got %h at %0d, expected 1234 at 3", rd, acka); end
  endtask

  task automatic test_full_width();
    int nwe, noe, oe, busy, ackc, acka, errc;
    logic [15:0] rd, ad0, dq0;
    do_access(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 6, nwe, noe, oe, busy, ackc, acka, errc, rd, ad0,
              dq0);
    n_checks++; if (ad0 !== 16'hFFFF) begin n_fail++;
      $display("FAIL full_addr: got %h, expected ffff", ad0); end
    n_checks++; if (dq0 !== 16'hFFFF) begin n_fail++;
      $display("FAIL full_dq_o: got %h, expected ffff", dq0); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) sram_mem[i] = 16'h0000;
    bus_a.mem_rd = 1'b0; bus_a.mem_wr = 1'b0; bus_a.mem_addr = '0; bus_a.mem_wdata = '0;
    bus_b.mem_rd = 1'b0; bus_b.mem_wr = 1'b0; bus_b.mem_addr = '0; bus_b.mem_wdata = '0;
    b_dq_i = 16'hBEEF;
    nRst = 1'b0;
    test_reset();
    test_write_read();
    test_rd_wr_both();
    test_back_to_back();
    test_zero_wait();
    test_reset_abort();
    test_full_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
